// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int CPU_ADDR_BITS   = 32;
  localparam int CPU_INST_BITS   = 32;
  localparam int FETCH_PKT_BYTES = 8;
  localparam int FETCH_PKT_BITS  = 2 * CPU_INST_BITS;
  localparam int FETCH_OFF_BITS  = $clog2(FETCH_PKT_BYTES);

  // Packet handed to the instruction buffer: inst0 address, inst0-invalid flag, {inst1, inst0}
  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0]  addr;
    logic                      kill;
    logic [FETCH_PKT_BITS-1:0] data;
  } fetch_pkt_t;

  // Tag remembered per in-flight request so the response can be paired with its PC
  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] addr;
    logic                     kill;
  } fetch_tag_t;

  // RUN: every response is live. DRAIN: stale responses from before a redirect still to discard.
  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_t;

  // Round an address down to its packet boundary
  function automatic logic [CPU_ADDR_BITS-1:0] pkt_align(input logic [CPU_ADDR_BITS-1:0] a);
    return {a[CPU_ADDR_BITS-1:FETCH_OFF_BITS], {FETCH_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_resp_queue.sv
// Small synchronous FIFO with a synchronous clear; head is visible combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: push into a full queue is ignored unless a pop happens the same cycle; clear wins.
module fetch_resp_queue
  import riscv_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_pkt_t),
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_pop   = pop_vld && head_vld;
  assign do_push  = push_vld && (!full || do_pop);

  // Pointer update; the extra wrap bit distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage; contents are don't-care while the slot is empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: issues aligned 2-instruction ICache requests and pushes in-order packets to the buffer.
// Latency: ICache response -> icache_dout_val 1 cycle; first request the cycle after rst drops.
// Backpressure: credit limit MAX_INFLIGHT over outstanding + queued; head holds while !inst_buffer_rdy.
// Optional FETCH_PERF_EN adds perf_fetch_pkts / perf_stall_cycles counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        icache_req_val,
  output logic [31:0] icache_req_addr,
  input  logic        icache_req_rdy,
  input  logic        icache_resp_val,
  input  logic [63:0] icache_resp_data,
  output logic [31:0] pc,
  output logic [63:0] icache_dout,
  output logic        icache_dout_val,
  input  logic        inst_buffer_rdy,
  output logic        fetch_inst0_kill
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_pkts,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          kill_pending;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] q_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   credits_used;
  logic          issue;
  logic          resp_keep;
  logic          pop;
  logic          tag_vld;
  fetch_tag_t    tag_in;
  fetch_tag_t    tag_head;
  fetch_pkt_t    pkt_in;
  fetch_pkt_t    pkt_head;

  // Credits cover requests in the ICache plus packets waiting here, so a response always has a slot
  assign credits_used    = {1'b0, outstanding} + {1'b0, q_count};
  assign icache_req_val  = !rst && !redirect_val && (credits_used < (CW + 1)'(MAX_INFLIGHT));
  assign icache_req_addr = fetch_pc;
  assign issue           = icache_req_val && icache_req_rdy;

  // A response arriving with a redirect is stale by definition; in DRAIN it belongs to the old path
  assign resp_keep = icache_resp_val && !redirect_val && (state == FETCH_RUN);
  assign pop       = icache_dout_val && inst_buffer_rdy;
  assign drop_next = outstanding - CW'(icache_resp_val);

  assign tag_in = '{addr: fetch_pc, kill: kill_pending};
  assign pkt_in = '{addr: tag_head.addr, kill: tag_head.kill, data: icache_resp_data};

  fetch_resp_queue #(
    .WIDTH ($bits(fetch_tag_t)),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_val),
    .push_vld (issue),
    .push_dat (tag_in),
    .pop_vld  (resp_keep),
    .head_dat (tag_head),
    .head_vld (tag_vld),
    .count    (tag_count)
  );

  fetch_resp_queue #(
    .WIDTH ($bits(fetch_pkt_t)),
    .DEPTH (MAX_INFLIGHT)
  ) u_out_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect_val),
    .push_vld (resp_keep),
    .push_dat (pkt_in),
    .pop_vld  (pop),
    .head_dat (pkt_head),
    .head_vld (icache_dout_val),
    .count    (q_count)
  );

  assign pc               = pkt_head.addr;
  assign icache_dout      = pkt_head.data;
  assign fetch_inst0_kill = icache_dout_val && pkt_head.kill;

  // Fetch PC, credit accounting and the RUN/DRAIN stale-response tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH_RUN;
      fetch_pc     <= pkt_align(RESET_PC);
      kill_pending <= 1'b0;
      outstanding  <= '0;
      drop_cnt     <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(icache_resp_val);
      if (redirect_val) begin
        fetch_pc     <= pkt_align(redirect_pc);
        kill_pending <= redirect_pc[2];
        drop_cnt     <= drop_next;
        state        <= (drop_next != '0) ? FETCH_DRAIN : FETCH_RUN;
      end else begin
        if (issue) begin
          fetch_pc     <= fetch_pc + 32'd8;
          kill_pending <= 1'b0;
        end
        if (icache_resp_val && state == FETCH_DRAIN) begin
          drop_cnt <= drop_cnt - 1'b1;
          if (drop_cnt == CW'(1)) state <= FETCH_RUN;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-packet and buffer-stall counters; free-running, wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_pkts   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (pop) perf_fetch_pkts <= perf_fetch_pkts + 32'd1;
      if (icache_dout_val && !inst_buffer_rdy) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  // The ICache only answers requests it was given
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(icache_resp_val && outstanding == '0));

  // Live tags are exactly the outstanding requests not marked for dropping
  a_tag_count: assert property (@(posedge clk) disable iff (rst)
    tag_count == outstanding - drop_cnt);

  // A kept response always finds its tag
  a_tag_present: assert property (@(posedge clk) disable iff (rst)
    resp_keep |-> tag_vld);

  // Redirect targets are instruction aligned
  a_redirect_align: assert property (@(posedge clk) disable iff (rst)
    redirect_val |-> redirect_pc[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a transaction-level ICache and buffer model.
// Latency: checks response->output 1 cycle and first request after reset.
// Backpressure: drives random inst_buffer_rdy / icache_req_rdy stalls.
module tb_fetch_unit;

  localparam int          MAXI = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        icache_req_val;
  logic [31:0] icache_req_addr;
  logic        icache_req_rdy;
  logic        icache_resp_val;
  logic [63:0] icache_resp_data;
  logic [31:0] pc;
  logic [63:0] icache_dout;
  logic        icache_dout_val;
  logic        inst_buffer_rdy;
  logic        fetch_inst0_kill;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_pkts;
  logic [31:0] perf_stall_cycles;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .MAX_INFLIGHT(MAXI)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_val     (redirect_val),
    .redirect_pc      (redirect_pc),
    .icache_req_val   (icache_req_val),
    .icache_req_addr  (icache_req_addr),
    .icache_req_rdy   (icache_req_rdy),
    .icache_resp_val  (icache_resp_val),
    .icache_resp_data (icache_resp_data),
    .pc               (pc),
    .icache_dout      (icache_dout),
    .icache_dout_val  (icache_dout_val),
    .inst_buffer_rdy  (inst_buffer_rdy),
    .fetch_inst0_kill (fetch_inst0_kill)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_pkts   (perf_fetch_pkts),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Request sitting in the ICache model; stale ones still come back but must be discarded
  typedef struct {
    logic [31:0] addr;
    logic        kill;
    logic        stale;
    logic [63:0] data;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic        kill;
    logic [63:0] data;
  } pkt_t;

  req_t pend[$];
  pkt_t mq[$];

  logic [31:0] m_pc;
  logic        m_kill;
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          n_run;
  int          n_fail;

  logic        t_rst, t_redir, t_req_rdy, t_buf_rdy;
  logic [31:0] t_rpc;

  logic        exp_resp, exp_req_val, exp_dout_val, exp_kill;
  logic [31:0] exp_addr, exp_pc;
  logic [63:0] exp_dout;

  // Apply this cycle's stimulus on the falling edge and derive expected outputs from the model
  task automatic drive();
    @(negedge clk);
    exp_resp = !t_rst && (pend.size() > 0) && (pend[0].due <= cyc);
    rst              = t_rst;
    redirect_val     = t_redir;
    redirect_pc      = t_rpc;
    icache_req_rdy   = t_req_rdy;
    inst_buffer_rdy  = t_buf_rdy;
    icache_resp_val  = exp_resp;
    icache_resp_data = exp_resp ? pend[0].data : 64'h0;
    exp_req_val  = !t_rst && !t_redir && ((pend.size() + mq.size()) < MAXI);
    exp_addr     = m_pc;
    exp_dout_val = (mq.size() > 0);
    exp_pc       = exp_dout_val ? mq[0].addr : 32'h0;
    exp_dout     = exp_dout_val ? mq[0].data : 64'h0;
    exp_kill     = exp_dout_val ? mq[0].kill : 1'b0;
  endtask

  // Advance the model across the rising edge
  task automatic advance();
    req_t r;
    pkt_t p;
    int   d;
    @(posedge clk);
    if (t_rst) begin
      pend.delete();
      mq.delete();
      m_pc     = RPC;
      m_kill   = 1'b0;
      last_due = 0;
    end else begin
      if (exp_dout_val && t_buf_rdy) void'(mq.pop_front());
      if (exp_resp) begin
        r = pend.pop_front();
        if (!r.stale && !t_redir) begin
          p.addr = r.addr;
          p.kill = r.kill;
          p.data = r.data;
          mq.push_back(p);
        end
      end
      if (t_redir) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        mq.delete();
        m_pc   = {t_rpc[31:3], 3'b000};
        m_kill = t_rpc[2];
      end else if (exp_req_val && t_req_rdy) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        r.addr  = m_pc;
        r.kill  = m_kill;
        r.stale = 1'b0;
        r.data  = {$urandom(), $urandom()};
        r.due   = d;
        pend.push_back(r);
        m_pc   = m_pc + 32'd8;
        m_kill = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    t_rst   = 1'b1;
    t_redir = 1'b0;
    repeat (2) begin
      drive();
      advance();
    end
    t_rst = 1'b0;
  endtask

  task automatic test_reset();
    t_rst = 1'b1; t_redir = 1'b0; t_rpc = 32'h0; t_req_rdy = 1'b1; t_buf_rdy = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (2) begin
      drive();
      advance();
    end
    drive(); #1;
    n_run++; if (icache_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_req_val got=%b exp=0", icache_req_val); end
    n_run++; if (icache_dout_val !== 1'b0) begin n_fail++; $display("FAIL reset_dout_val got=%b exp=0", icache_dout_val); end
    n_run++; if (fetch_inst0_kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill got=%b exp=0", fetch_inst0_kill); end
    advance();
    t_rst = 1'b0;
    drive(); #1;
    n_run++;
    if (icache_req_val !== 1'b1 || icache_req_addr !== RPC) begin
      n_fail++; $display("FAIL first_req got val=%b addr=%h exp val=1 addr=%h", icache_req_val, icache_req_addr, RPC);
    end
    advance();
  endtask

  task automatic test_basic();
    logic [31:0] exp_seq;
    exp_seq = RPC;
    t_req_rdy = 1'b1; t_buf_rdy = 1'b1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) begin
      drive(); #1;
      n_run++; if (icache_req_val !== exp_req_val) begin n_fail++; $display("FAIL basic_req_val cyc=%0d got=%b exp=%b", cyc, icache_req_val, exp_req_val); end
      if (exp_req_val) begin n_run++; if (icache_req_addr !== exp_addr) begin n_fail++; $display("FAIL basic_req_addr cyc=%0d got=%h exp=%h", cyc, icache_req_addr, exp_addr); end end
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL basic_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (exp_dout_val) begin
        n_run++;
        if (pc !== exp_pc || icache_dout !== exp_dout || fetch_inst0_kill !== exp_kill) begin
          n_fail++; $display("FAIL basic_head cyc=%0d got pc=%h d=%h k=%b exp pc=%h d=%h k=%b", cyc, pc, icache_dout, fetch_inst0_kill, exp_pc, exp_dout, exp_kill);
        end
        n_run++; if (pc !== exp_seq) begin n_fail++; $display("FAIL basic_seq got=%h exp=%h", pc, exp_seq); end
        exp_seq = exp_seq + 32'd8;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    t_req_rdy = 1'b1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 22; i++) begin
      t_buf_rdy = (i >= 11);
      drive(); #1;
      n_run++; if (icache_req_val !== exp_req_val) begin n_fail++; $display("FAIL bp_req_val cyc=%0d got=%b exp=%b", cyc, icache_req_val, exp_req_val); end
      if (exp_req_val) begin n_run++; if (icache_req_addr !== exp_addr) begin n_fail++; $display("FAIL bp_req_addr cyc=%0d got=%h exp=%h", cyc, icache_req_addr, exp_addr); end end
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL bp_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (exp_dout_val) begin
        n_run++;
        if (pc !== exp_pc || icache_dout !== exp_dout || fetch_inst0_kill !== exp_kill) begin
          n_fail++; $display("FAIL bp_head cyc=%0d got pc=%h d=%h exp pc=%h d=%h", cyc, pc, icache_dout, exp_pc, exp_dout);
        end
      end
      if (i == 10) begin
        n_run++;
        if (icache_req_val !== 1'b0 || icache_dout_val !== 1'b1) begin
          n_fail++; $display("FAIL bp_full got req_val=%b dout_val=%b exp req_val=0 dout_val=1", icache_req_val, icache_dout_val);
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    int   npop;
    logic seen_req;
    do_reset();
    t_req_rdy = 1'b1; t_buf_rdy = 1'b1; lat_min = 6; lat_max = 6;
    for (int i = 0; i < 2; i++) begin
      drive(); #1;
      n_run++; if (icache_req_val !== 1'b1) begin n_fail++; $display("FAIL redir_setup_req got=%b exp=1", icache_req_val); end
      advance();
    end
    t_redir = 1'b1; t_rpc = 32'h0000_0104; lat_min = 1; lat_max = 1;
    drive(); #1;
    n_run++; if (icache_req_val !== 1'b0) begin n_fail++; $display("FAIL redir_no_req got=%b exp=0", icache_req_val); end
    advance();
    t_redir = 1'b0;
    npop = 0; seen_req = 1'b0;
    for (int i = 0; i < 30 && npop < 2; i++) begin
      drive(); #1;
      n_run++; if (icache_req_val !== exp_req_val) begin n_fail++; $display("FAIL redir_req_val cyc=%0d got=%b exp=%b", cyc, icache_req_val, exp_req_val); end
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL redir_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (!seen_req && icache_req_val) begin
        seen_req = 1'b1;
        n_run++; if (icache_req_addr !== 32'h100) begin n_fail++; $display("FAIL redir_first_req got=%h exp=00000100", icache_req_addr); end
      end
      if (icache_dout_val) begin
        n_run++;
        if (pc !== (npop == 0 ? 32'h100 : 32'h108) || fetch_inst0_kill !== (npop == 0)) begin
          n_fail++; $display("FAIL redir_pkt%0d got pc=%h kill=%b", npop, pc, fetch_inst0_kill);
        end
        n_run++; if (icache_dout !== exp_dout) begin n_fail++; $display("FAIL redir_data got=%h exp=%h", icache_dout, exp_dout); end
        npop++;
      end
      advance();
    end
    n_run++; if (npop != 2) begin n_fail++; $display("FAIL redir_timeout got %0d pkts exp 2", npop); end
  endtask

  task automatic test_redirect_resp_pop();
    logic hit;
    do_reset();
    t_req_rdy = 1'b1; t_buf_rdy = 1'b1; lat_min = 1; lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
        hit = 1'b1; t_redir = 1'b1; t_rpc = 32'h0000_0200;
      end
      drive(); #1;
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL rrp_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (hit) begin
        n_run++;
        if (icache_req_val !== 1'b0 || icache_dout_val !== 1'b1 || icache_resp_val !== 1'b1) begin
          n_fail++; $display("FAIL rrp_cycle got req_val=%b dout_val=%b exp req_val=0 dout_val=1", icache_req_val, icache_dout_val);
        end
      end
      advance();
      t_redir = 1'b0;
    end
    n_run++; if (!hit) begin n_fail++; $display("FAIL rrp_setup got no resp+pop cycle exp one"); end
    drive(); #1;
    n_run++;
    if (icache_dout_val !== 1'b0 || icache_req_val !== 1'b1 || icache_req_addr !== 32'h200) begin
      n_fail++; $display("FAIL rrp_after got dout_val=%b req_val=%b addr=%h exp 0 1 00000200", icache_dout_val, icache_req_val, icache_req_addr);
    end
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(); #1;
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL rrp_post_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (exp_dout_val) begin n_run++; if (pc !== exp_pc || icache_dout !== exp_dout) begin n_fail++; $display("FAIL rrp_post_head got pc=%h exp=%h", pc, exp_pc); end end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wl [3];
    int          k;
    wl = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
    do_reset();
    t_req_rdy = 1'b1; t_buf_rdy = 1'b1; lat_min = 1; lat_max = 2;
    t_redir = 1'b1; t_rpc = 32'hFFFF_FFF8;
    drive(); advance();
    t_redir = 1'b0;
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      drive(); #1;
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL wrap_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (icache_req_val && t_req_rdy) begin
        n_run++; if (icache_req_addr !== wl[k]) begin n_fail++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, icache_req_addr, wl[k]); end
        k++;
      end
      advance();
    end
    n_run++; if (k != 3) begin n_fail++; $display("FAIL wrap_timeout got %0d reqs exp 3", k); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom();
      t_req_rdy = ($urandom_range(3, 0) != 0);
      t_buf_rdy = ($urandom_range(3, 0) != 0);
      t_redir   = ($urandom_range(19, 0) == 0);
      t_rpc     = (r[31:30] == 2'b11) ? {29'h1FFF_FFFF, r[2], 2'b00} : {r[31:2], 2'b00};
      t_rst     = ($urandom_range(299, 0) == 0);
      drive(); #1;
      n_run++; if (icache_req_val !== exp_req_val) begin n_fail++; $display("FAIL rnd_req_val cyc=%0d got=%b exp=%b", cyc, icache_req_val, exp_req_val); end
      if (exp_req_val) begin n_run++; if (icache_req_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, icache_req_addr, exp_addr); end end
      n_run++; if (icache_dout_val !== exp_dout_val) begin n_fail++; $display("FAIL rnd_dout_val cyc=%0d got=%b exp=%b", cyc, icache_dout_val, exp_dout_val); end
      if (exp_dout_val) begin
        n_run++;
        if (pc !== exp_pc || icache_dout !== exp_dout || fetch_inst0_kill !== exp_kill) begin
          n_fail++; $display("FAIL rnd_head cyc=%0d got pc=%h d=%h k=%b exp pc=%h d=%h k=%b", cyc, pc, icache_dout, fetch_inst0_kill, exp_pc, exp_dout, exp_kill);
        end
      end
      advance();
    end
    t_rst = 1'b0; t_redir = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int pops;
    int stalls;
    do_reset();
    t_req_rdy = 1'b1; lat_min = 1; lat_max = 1;
    pops = 0; stalls = 0;
    t_buf_rdy = 1'b1;
    drive(); #1;
    n_run++;
    if (perf_fetch_pkts !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset got pkts=%0d stalls=%0d exp 0 0", perf_fetch_pkts, perf_stall_cycles);
    end
    advance();
    for (int i = 0; i < 60 && pops < 5; i++) begin
      t_buf_rdy = (stalls >= 3);
      drive(); #1;
      if (exp_dout_val) begin
        if (t_buf_rdy) pops++;
        else stalls++;
      end
      advance();
    end
    t_buf_rdy = 1'b0;
    drive(); #1;
    n_run++;
    if (perf_fetch_pkts !== 32'd5 || perf_stall_cycles !== 32'd3) begin
      n_fail++; $display("FAIL perf_counts got pkts=%0d stalls=%0d exp 5 3", perf_fetch_pkts, perf_stall_cycles);
    end
    advance();
  endtask
`endif

  initial begin
    rst = 1'b1; redirect_val = 1'b0; redirect_pc = 32'h0; icache_req_rdy = 1'b0;
    icache_resp_val = 1'b0; icache_resp_data = 64'h0; inst_buffer_rdy = 1'b0;
    cyc = 0; last_due = 0; n_run = 0; n_fail = 0;
    m_pc = RPC; m_kill = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_resp_pop();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
